// File: rtl/direction_conditioner.sv
// direction_conditioner
//   One player's direction input stage: synchronises and debounces the four
//   active-low GPIO buttons, latches the most recent press as a pending turn,
//   commits it on the game tick and discards 180-degree reversals.
// Ports:
//   clk           system clock (CLOCK_50 domain)
//   clear         asynchronous active-low reset
//   btn_n[3:0]    raw buttons, active-low: bit0 up, bit1 right, bit2 down, bit3 left
//   tick          one-cycle game update strobe
//   game_run      high while a round is in play
//   movement[4:0] committed one-hot direction (00010 up, 10000 right,
//                 01000 down, 00100 left, 00000 stopped)
//   pending       a turn request is latched and waiting for a tick
//   btn_clean[3:0] debounced buttons, active-high
//   turn_rejected one-cycle pulse when a reversal is discarded at tick
module direction_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] btn_n,
    input  logic       tick,
    input  logic       game_run,
    output logic [4:0] movement,
    output logic       pending,
    output logic [3:0] btn_clean,
    output logic       turn_rejected
);

    typedef enum logic [1:0] {IDLE, ARMED, PENDING} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [4:0] MV_UP    = 5'b00010;
    localparam logic [4:0] MV_RIGHT = 5'b10000;
    localparam logic [4:0] MV_DOWN  = 5'b01000;
    localparam logic [4:0] MV_LEFT  = 5'b00100;

    state_t           state;
    logic [3:0]       sync1, sync2;
    logic [3:0]       level;       // accepted (debounced) level, active-low
    logic [3:0]       clean_d;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       press;
    logic [4:0]       press_code;
    logic [4:0]       req;
    logic [4:0]       opposite;
    logic             reversal;

    // Two-flop synchroniser; idles released (1) out of reset.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: the synchronised level must disagree with the
    // accepted level for DEBOUNCE_CYCLES consecutive cycles to be taken.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            level <= '1;
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_clean = ~level;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) clean_d <= '0;
        else        clean_d <= btn_clean;
    end

    assign press = btn_clean & ~clean_d;

    // Simultaneous presses resolve up > right > down > left.
    always_comb begin
        press_code = '0;
        if      (press[0]) press_code = MV_UP;
        else if (press[1]) press_code = MV_RIGHT;
        else if (press[2]) press_code = MV_DOWN;
        else if (press[3]) press_code = MV_LEFT;
    end

    // Swap up<->down and right<->left within the one-hot code.
    assign opposite = {movement[2], movement[1], movement[4], movement[3], movement[0]};
    assign reversal = (movement != '0) && (req == opposite);

    // The tick always acts on the request held before this cycle; a press in
    // the same cycle is latched afterwards and waits for the following tick.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state         <= IDLE;
            movement      <= '0;
            pending       <= 1'b0;
            req           <= '0;
            turn_rejected <= 1'b0;
        end else begin
            turn_rejected <= 1'b0;
            if (!game_run) begin
                state    <= IDLE;
                movement <= '0;
                pending  <= 1'b0;
                req      <= '0;
            end else begin
                case (state)
                    IDLE, ARMED: begin
                        if (|press) begin
                            req     <= press_code;
                            pending <= 1'b1;
                            state   <= PENDING;
                        end else begin
                            state <= ARMED;
                        end
                    end
                    PENDING: begin
                        if (tick) begin
                            if (reversal) turn_rejected <= 1'b1;
                            else          movement      <= req;
                            if (|press) begin
                                req <= press_code;
                            end else begin
                                req     <= '0;
                                pending <= 1'b0;
                                state   <= ARMED;
                            end
                        end else if (|press) begin
                            req <= press_code;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_direction_conditioner.sv
// tb_direction_conditioner
//   Randomised bench for direction_conditioner with DEBOUNCE_CYCLES=4.
//   A behavioural model tracks directions as indices 0..3 (up, right, down,
//   left), where the reverse of d is (d+2)%4, and compares all outputs every
//   cycle on the falling edge.
module tb_direction_conditioner;

    localparam int DB = 4;

    logic       clk;
    logic       clear;
    logic [3:0] btn_n;
    logic       tick;
    logic       game_run;
    logic [4:0] movement;
    logic       pending;
    logic [3:0] btn_clean;
    logic       turn_rejected;

    direction_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (3)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .btn_n        (btn_n),
        .tick         (tick),
        .game_run     (game_run),
        .movement     (movement),
        .pending      (pending),
        .btn_clean    (btn_clean),
        .turn_rejected(turn_rejected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [4:0] code_of [4];
    logic [3:0] m_delay [$];       // raw samples in flight through the synchroniser
    logic [3:0] m_acc;             // accepted active-low level per button
    int         m_run [4];         // consecutive samples disagreeing with m_acc
    logic [3:0] m_clean_prev;
    int         m_req;             // -1 = no request
    int         m_mov;             // -1 = stopped
    bit         m_pend;
    bit         m_rej;
    logic [3:0] m_s, m_press;
    int         m_nd;

    initial begin
        code_of[0] = 5'b00010;
        code_of[1] = 5'b10000;
        code_of[2] = 5'b01000;
        code_of[3] = 5'b00100;
    end

    function automatic logic [4:0] mov_code(input int d);
        return (d < 0) ? 5'b00000 : code_of[d];
    endfunction

    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            m_delay = {4'hF, 4'hF};
            m_acc = 4'hF;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_clean_prev = 4'h0;
            m_req = -1; m_mov = -1; m_pend = 0; m_rej = 0;
        end else begin
            m_press = ~m_acc & ~m_clean_prev;
            m_clean_prev = ~m_acc;
            m_s = m_delay.pop_front();
            m_delay.push_back(btn_n);
            for (int i = 0; i < 4; i++) begin
                if (m_s[i] != m_acc[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_acc[i] = m_s[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_rej = 0;
            if (!game_run) begin
                m_mov = -1; m_pend = 0; m_req = -1;
            end else begin
                if (tick && m_pend) begin
                    if (m_mov >= 0 && m_req == (m_mov + 2) % 4) m_rej = 1;
                    else m_mov = m_req;
                    m_pend = 0;
                    m_req = -1;
                end
                m_nd = -1;
                for (int d = 3; d >= 0; d--) if (m_press[d]) m_nd = d;
                if (m_nd >= 0) begin
                    m_req = m_nd;
                    m_pend = 1;
                end
            end
        end
    end

    task automatic compare_all();
        check("movement",      {3'b0, movement},      {3'b0, mov_code(m_mov)});
        check("pending",       {7'b0, pending},       {7'b0, m_pend});
        check("btn_clean",     {4'b0, btn_clean},     {4'b0, ~m_acc});
        check("turn_rejected", {7'b0, turn_rejected}, {7'b0, m_rej});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_movement"},  {3'b0, movement},      8'h00);
        check({tag, "_pending"},   {7'b0, pending},       8'h00);
        check({tag, "_btn_clean"}, {4'b0, btn_clean},     8'h00);
        check({tag, "_rejected"},  {7'b0, turn_rejected}, 8'h00);
    endtask

    // ---------------- stimulus ----------------
    int unsigned hold;
    int unsigned gr_low;

    initial begin
        clear    = 1'b0;
        btn_n    = 4'h0;
        tick     = 1'b0;
        game_run = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        compare_all();
        clear  = 1'b1;
        hold   = 10;
        gr_low = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            compare_all();

            if (cyc == 2000) begin
                #2 clear = 1'b0;
                #1 check_zero("async_reset");
                @(negedge clk);
                @(negedge clk);
                compare_all();
                clear = 1'b1;
            end

            if (hold == 0) begin
                if ($urandom_range(0, 1) == 0) btn_n = 4'hF;
                else btn_n = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 12);
            end else begin
                hold--;
            end

            tick = ($urandom_range(0, 5) == 0);

            if (cyc < 12) begin
                game_run = 1'b0;
            end else if (gr_low != 0) begin
                game_run = 1'b0;
                gr_low--;
            end else if ($urandom_range(0, 199) == 0) begin
                game_run = 1'b0;
                gr_low = $urandom_range(1, 8);
            end else begin
                game_run = 1'b1;
            end
        end

        @(negedge clk);
        compare_all();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
